// File: rtl/e203_irq_stim.sv
// Interrupt stimulus generator for the E203 core: after an arming commit, each of the
// ext/sft/tmr lines is raised after a pseudo-random wait and dropped when its handler commits.
`timescale 1ns/1ps
module e203_irq_stim #(
  parameter int                 PC_SIZE    = 32,
  parameter logic [PC_SIZE-1:0] ARM_PC     = 32'h8000015C,
  parameter logic [PC_SIZE-1:0] TOHOST_PC  = 32'h80000086,
  parameter logic [PC_SIZE-1:0] EXT_ACK_PC = 32'h800000a6,
  parameter logic [PC_SIZE-1:0] SFT_ACK_PC = 32'h800000be,
  parameter logic [PC_SIZE-1:0] TMR_ACK_PC = 32'h800000d6,
  parameter int                 STOP_CNT   = 32,
  parameter int                 WAIT_W     = 10,
  parameter logic [31:0]        LFSR_SEED  = 32'hACE1_2D5B
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cmt_valid,
  input  logic [PC_SIZE-1:0] cmt_pc,
  output logic               ext_irq,
  output logic               sft_irq,
  output logic               tmr_irq,
  output logic               armed,
  output logic               stopped,
  output logic [31:0]        tohost_cnt,
  output logic               all_idle
);

  typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_ASSERT, ST_DONE} state_t;

  localparam logic [WAIT_W:0] CNT_ONE  = 1;
  localparam logic [31:0]     STOP_LIM = STOP_CNT;

  logic [31:0] lfsr_reg;
  logic        armed_reg;
  logic [31:0] tohost_reg;
  logic [2:0]  irq_vec;

  // Fibonacci LFSR, taps 32,22,2,1; free-running so wait values do not depend on en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_reg <= 1'b0;
    end else if (!en) begin
      armed_reg <= 1'b0;
    end else if (cmt_valid && (cmt_pc == ARM_PC)) begin
      armed_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_reg <= '0;
    end else if (cmt_valid && (cmt_pc == TOHOST_PC) && (tohost_reg != 32'hFFFF_FFFF)) begin
      tohost_reg <= tohost_reg + 32'd1;
    end
  end

  assign stopped    = (tohost_reg > STOP_LIM);
  assign armed      = armed_reg;
  assign tohost_cnt = tohost_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    localparam logic [PC_SIZE-1:0] ACK_PC = (gi == 0) ? EXT_ACK_PC :
                                            (gi == 1) ? SFT_ACK_PC : TMR_ACK_PC;

    state_t          state_reg, state_next;
    logic [WAIT_W:0] cnt_reg, cnt_next;
    logic [WAIT_W:0] load_val;
    logic            irq_reg;
    logic            ack;

    // One extra bit so a slice of all ones still loads 2^WAIT_W.
    assign load_val = {1'b0, lfsr_reg[gi*WAIT_W +: WAIT_W]} + CNT_ONE;
    assign ack      = cmt_valid && (cmt_pc == ACK_PC);

    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (!en) begin
        state_next = ST_OFF;
      end else begin
        case (state_reg)
          ST_OFF: begin
            if (armed_reg) begin
              state_next = ST_WAIT;
              cnt_next   = load_val;
            end
          end
          ST_WAIT: begin
            if (cnt_reg == CNT_ONE) begin
              state_next = ST_ASSERT;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
          ST_ASSERT: begin
            if (ack) begin
              if (stopped) begin
                state_next = ST_DONE;
              end else begin
                state_next = ST_WAIT;
                cnt_next   = load_val;
              end
            end
          end
          ST_DONE:  state_next = ST_DONE;
          default:  state_next = ST_OFF;
        endcase
      end
    end

    // irq is its own flop (not decoded from state) so the line is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_reg <= ST_OFF;
        cnt_reg   <= '0;
        irq_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        irq_reg   <= (state_next == ST_ASSERT);
      end
    end

    assign irq_vec[gi] = irq_reg;
  end

  assign ext_irq  = irq_vec[0];
  assign sft_irq  = irq_vec[1];
  assign tmr_irq  = irq_vec[2];
  assign all_idle = ~|irq_vec;

endmodule

// File: tb/tb_e203_irq_stim.sv
// Randomized bench for e203_irq_stim: an event-time reference model pushes expected
// output snapshots into a queue; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_e203_irq_stim;

  localparam logic [31:0] ARM    = 32'h8000015C;
  localparam logic [31:0] TOHOST = 32'h80000086;
  localparam logic [31:0] EXT_AK = 32'h800000a6;
  localparam logic [31:0] SFT_AK = 32'h800000be;
  localparam logic [31:0] TMR_AK = 32'h800000d6;
  localparam int          STOPN  = 32;
  localparam int          WW     = 10;
  localparam logic [31:0] SEED   = 32'hACE1_2D5B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cmt_valid = 1'b0;
  logic [31:0] cmt_pc = '0;
  logic        ext_irq, sft_irq, tmr_irq, armed, stopped, all_idle;
  logic [31:0] tohost_cnt;

  e203_irq_stim #(
    .PC_SIZE(32), .ARM_PC(ARM), .TOHOST_PC(TOHOST), .EXT_ACK_PC(EXT_AK),
    .SFT_ACK_PC(SFT_AK), .TMR_ACK_PC(TMR_AK), .STOP_CNT(STOPN), .WAIT_W(WW),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .ext_irq(ext_irq), .sft_irq(sft_irq), .tmr_irq(tmr_irq), .armed(armed),
    .stopped(stopped), .tohost_cnt(tohost_cnt), .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Snapshot layout: {tmr,sft,ext, armed, stopped, all_idle, tohost_cnt}
  logic [37:0] exp_q[$];

  // Reference model: per channel, a pending rise time in absolute edge numbers.
  logic [31:0] m_lfsr;
  logic        m_armed;
  logic [31:0] m_cnt;
  logic [2:0]  m_high, m_pend, m_done;
  int          m_rise_at[3];
  int          cyc = 0;

  function automatic logic [31:0] ack_pc(input int ch);
    case (ch)
      0:       return EXT_AK;
      1:       return SFT_AK;
      default: return TMR_AK;
    endcase
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_armed = 1'b0; m_cnt = '0;
    m_high = '0; m_pend = '0; m_done = '0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] pc, input logic e);
    logic stop_now;
    logic fb;
    int   n;
    stop_now = (m_cnt > STOPN);
    cyc++;
    if (!e) begin
      m_armed = 1'b0; m_high = '0; m_pend = '0; m_done = '0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        n = int'((m_lfsr >> (ch * WW)) & ((32'd1 << WW) - 32'd1)) + 1;
        if (m_done[ch]) begin
          m_done[ch] = 1'b1;
        end else if (m_high[ch]) begin
          if (v && pc == ack_pc(ch)) begin
            m_high[ch] = 1'b0;
            if (stop_now) m_done[ch] = 1'b1;
            else begin m_pend[ch] = 1'b1; m_rise_at[ch] = cyc + n; end
          end
        end else if (m_pend[ch]) begin
          if (cyc == m_rise_at[ch]) begin m_pend[ch] = 1'b0; m_high[ch] = 1'b1; end
        end else if (m_armed) begin
          m_pend[ch] = 1'b1; m_rise_at[ch] = cyc + n;
        end
      end
      if (v && pc == ARM) m_armed = 1'b1;
    end
    if (v && pc == TOHOST && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    fb = m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0];
    m_lfsr = (m_lfsr << 1) | {31'd0, fb};
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic e);
    cmt_valid = v; cmt_pc = pc; en = e;
    model_edge(v, pc, e);
    @(posedge clk);
    exp_q.push_back({m_high[2], m_high[1], m_high[0], m_armed, (m_cnt > STOPN), ~|m_high, m_cnt});
    #1;
  endtask

  task automatic rand_step(input bit acks);
    int r, ch;
    r = $urandom_range(0, 15);
    if (acks && (|m_high) && r < 4) begin
      ch = $urandom_range(0, 2);
      for (int k = 0; k < 3; k++) if (!m_high[ch]) ch = (ch + 1) % 3;
      step(1'b1, ack_pc(ch), 1'b1);
    end else if (acks && r == 5) begin
      step(1'b1, ack_pc($urandom_range(0, 2)), 1'b1);
    end else if (r == 6) begin
      step(1'b1, $urandom & 32'h7FFF_FFF0, 1'b1);
    end else begin
      step(1'b0, $urandom, 1'b1);
    end
  endtask

  task automatic wait_high(input int ch, input int budget);
    int k;
    k = 0;
    while (!m_high[ch] && k < budget) begin rand_step(1'b0); k++; end
    checks++;
    if (!m_high[ch]) begin
      errors++;
      $display("FAIL wait_high ch=%0d: no rise after %0d cycles, required rise", ch, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; #1;
    checks++;
    if ({tmr_irq, sft_irq, ext_irq, armed, stopped, all_idle, tohost_cnt} !== {6'b000001, 32'd0}) begin
      errors++;
      $display("FAIL async_reset: irq=%b armed=%b stopped=%b idle=%b cnt=%0d, required irq=000 armed=0 stopped=0 idle=1 cnt=0",
               {tmr_irq, sft_irq, ext_irq}, armed, stopped, all_idle, tohost_cnt);
    end
    model_reset();
    cmt_valid = 1'b0; en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compares every presented snapshot and logs irq edges as transactions.
  initial begin
    logic [37:0] exp_v, act_v;
    logic [2:0]  prev_irq;
    prev_irq = '0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {tmr_irq, sft_irq, ext_irq, armed, stopped, all_idle, tohost_cnt};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL state t=%0t: irq=%b armed=%b stopped=%b idle=%b cnt=%0d, required irq=%b armed=%b stopped=%b idle=%b cnt=%0d",
                   $time, act_v[37:35], act_v[34], act_v[33], act_v[32], act_v[31:0],
                   exp_v[37:35], exp_v[34], exp_v[33], exp_v[32], exp_v[31:0]);
        end
        for (int ch = 0; ch < 3; ch++) begin
          if (act_v[35+ch] !== prev_irq[ch])
            $display("txn t=%0t ch=%0d irq %s", $time, ch, act_v[35+ch] ? "rise" : "fall");
        end
        prev_irq = act_v[37:35];
      end
    end
  end

  initial begin
    int k;
    model_reset();
    #2;
    checks++;
    if ({tmr_irq, sft_irq, ext_irq, armed, stopped, all_idle, tohost_cnt} !== {6'b000001, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: irq=%b armed=%b cnt=%0d, required irq=000 armed=0 cnt=0",
               {tmr_irq, sft_irq, ext_irq}, armed, tohost_cnt);
    end
    en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Enabled but never armed: nothing may fire.
    for (int i = 0; i < 2000; i++) step(1'b0, $urandom, 1'b1);

    // Arm, let ext fire, ack it, then random traffic with acks.
    step(1'b1, ARM, 1'b1);
    wait_high(0, 3000);
    step(1'b1, EXT_AK, 1'b1);
    for (int i = 0; i < 3000; i++) rand_step(1'b1);

    // Reset in the middle of a tmr assertion, then replay from the seed.
    wait_high(2, 3000);
    do_reset();
    step(1'b1, ARM, 1'b1);
    for (int i = 0; i < 1500; i++) rand_step(1'b1);

    // Drop en while sft is high, then re-arm.
    wait_high(1, 3000);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, $urandom, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, $urandom, 1'b1);
    step(1'b1, ARM, 1'b1);
    for (int i = 0; i < 2000; i++) rand_step(1'b1);

    // Cross the stop threshold; each channel finishes one more round then parks.
    for (int i = 0; i < 33; i++) step(1'b1, TOHOST, 1'b1);
    k = 0;
    while (m_done != 3'b111 && k < 12000) begin rand_step(1'b1); k++; end
    checks++;
    if (m_done != 3'b111) begin
      errors++;
      $display("FAIL all_done: done=%b after %0d cycles, required 111", m_done, k);
    end
    for (int i = 0; i < 5000; i++) rand_step(1'b1);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d snapshots left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
